// File: rtl/ram_sync_dp_be.sv
// ram_sync_dp_be: simple dual-port synchronous RAM with byte-enabled writes,
// a separate read port with a rd_valid strobe, selectable read latency and
// read-during-write behaviour, and a clear engine that zeroes the array
// after reset.
//
// Optional feature macro: RAM_SYNC_DP_PARITY_EN. When it is defined, the
// array stores one even-parity bit per byte and reports read mismatches on
// rd_perr. When it is undefined, rd_perr is tied low and wr_perr_inj is
// ignored.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   wr_en        write request
//   wr_addr      write address
//   wr_data      write data
//   wr_be        byte enables; bit i covers wr_data[8i+7:8i]
//   rd_en        read request
//   rd_addr      read address
//   rd_data      registered read data; holds its value between results
//   rd_valid     single-cycle pulse marking a new rd_data result
//   init_busy    clear engine active; requests are ignored
//   rd_perr      parity error on the current read (parity builds only)
//   wr_perr_inj  store inverted byte-0 parity on this write (parity builds only)
module ram_sync_dp_be #(
  parameter int unsigned AWIDTH         = 3,
  parameter int unsigned DWIDTH         = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [AWIDTH-1:0]       wr_addr,
  input  logic [DWIDTH-1:0]       wr_data,
  input  logic [(DWIDTH/8)-1:0]   wr_be,
  input  logic                    rd_en,
  input  logic [AWIDTH-1:0]       rd_addr,
  output logic [DWIDTH-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    init_busy,
  output logic                    rd_perr,
  input  logic                    wr_perr_inj
);

  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned NBYTES = DWIDTH / 8;

  // Reject illegal configurations at elaboration.
  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("ram_sync_dp_be: RD_LATENCY must be 1 or 2");
    end
    if (DWIDTH == 0 || (DWIDTH % 8) != 0) begin : g_bad_dwidth
      $error("ram_sync_dp_be: DWIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic                init_busy_q, init_busy_d;

  logic [DWIDTH-1:0]   mem_q [DEPTH];

  // Single array write port shared by the clear engine and the user port.
  logic                mem_we_c;
  logic [AWIDTH-1:0]   mem_waddr_c;
  logic [DWIDTH-1:0]   mem_wdata_c;
  logic [NBYTES-1:0]   mem_wbe_c;

  logic                rd_fire_c;
  logic                collide_c;
  logic [DWIDTH-1:0]   rd_word_c;
  logic                rd_perr_c;

  logic                rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0]   rd_data_q, rd_data_d;
  logic                rd_perr_q, rd_perr_d;

  // Clear engine next state and array write-port selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr;
    mem_wdata_c = wr_data;
    mem_wbe_c   = wr_be;
    rd_fire_c   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = '0;
        mem_wbe_c   = '1;
        cnt_d       = cnt_q + AWIDTH'(1);
        if (cnt_q == AWIDTH'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we_c  = wr_en;
        rd_fire_c = rd_en;
      end
      default: state_d = ST_RUN;
    endcase
    init_busy_d = (state_d == ST_CLEAR);
  end

  // Array write: only enabled byte lanes are touched.
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (mem_wbe_c[i]) begin
          mem_q[mem_waddr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
        end
      end
    end
  end

  // Read word at the sampling edge; write-through merges the concurrent write.
  always_comb begin
    collide_c = (RDW_MODE == 1) && mem_we_c && (mem_waddr_c == rd_addr);
    rd_word_c = mem_q[rd_addr];
    if (collide_c) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (mem_wbe_c[i]) begin
          rd_word_c[8*i +: 8] = mem_wdata_c[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_SYNC_DP_PARITY_EN
  logic [NBYTES-1:0]   par_q [DEPTH];
  logic [NBYTES-1:0]   mem_wpar_c;
  logic [NBYTES-1:0]   rd_par_c;

  // Even parity per lane; injection flips lane 0 of a user write only.
  always_comb begin
    mem_wpar_c = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      mem_wpar_c[i] = ^mem_wdata_c[8*i +: 8];
    end
    if (state_q == ST_RUN && wr_perr_inj) begin
      mem_wpar_c[0] = ~mem_wpar_c[0];
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (mem_wbe_c[i]) begin
          par_q[mem_waddr_c][i] <= mem_wpar_c[i];
        end
      end
    end
  end

  // Parity follows the same read-old / write-through choice as the data.
  always_comb begin
    rd_par_c = par_q[rd_addr];
    if (collide_c) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (mem_wbe_c[i]) begin
          rd_par_c[i] = mem_wpar_c[i];
        end
      end
    end
    rd_perr_c = 1'b0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      rd_perr_c = rd_perr_c | (rd_par_c[i] ^ (^rd_word_c[8*i +: 8]));
    end
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = wr_perr_inj;
  assign rd_perr_c       = 1'b0;
`endif

  // Read pipeline: the word is captured at the sampling edge, so later
  // writes cannot affect a read already in flight.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      always_comb begin
        rd_valid_d = rd_fire_c;
        rd_data_d  = rd_fire_c ? rd_word_c : rd_data_q;
        rd_perr_d  = rd_fire_c & rd_perr_c;
      end
    end else begin : g_lat2
      logic              s1_valid_q, s1_valid_d;
      logic [DWIDTH-1:0] s1_data_q, s1_data_d;
      logic              s1_perr_q, s1_perr_d;

      always_comb begin
        s1_valid_d = rd_fire_c;
        s1_data_d  = rd_fire_c ? rd_word_c : s1_data_q;
        s1_perr_d  = rd_fire_c & rd_perr_c;
        rd_valid_d = s1_valid_q;
        rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
        rd_perr_d  = s1_valid_q & s1_perr_q;
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
          s1_perr_q  <= 1'b0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_data_q  <= s1_data_d;
          s1_perr_q  <= s1_perr_d;
        end
      end
    end
  endgenerate

  // Control and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q       <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_perr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_perr_q   <= rd_perr_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_perr   = rd_perr_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Testbench for ram_sync_dp_be. Two instances share the input stimulus:
// dut0 uses read latency 1 with read-old collisions, dut1 uses read latency 2
// with write-through collisions. A behavioural memory model predicts every
// read result into a per-instance queue, and a monitor on the falling edge
// compares what each instance presents.
module tb_ram_sync_dp_be;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic        wr_perr_inj;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        init_busy0, init_busy1;
  logic        rd_perr0, rd_perr1;

  ram_sync_dp_be #(
    .AWIDTH(3), .DWIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(init_busy0),
    .rd_perr(rd_perr0), .wr_perr_inj(wr_perr_inj)
  );

  ram_sync_dp_be #(
    .AWIDTH(3), .DWIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1),
    .rd_perr(rd_perr1), .wr_perr_inj(wr_perr_inj)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_inj [DEPTH];
  int          clear_left = DEPTH;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_d0 = '0;
  logic [31:0] last_d1 = '0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  // Only the parity build reports corrupted byte-0 parity.
  function automatic logic perr_of(input bit inj);
`ifdef RAM_SYNC_DP_PARITY_EN
    return inj;
`else
    return 1'b0 & inj;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reset discards all predicted results and restarts the clear window.
  always @(negedge reset_n) begin
    q0.delete();
    q1.delete();
    clear_left = DEPTH;
  end

  // Reference model: clear window, then read-old / write-through semantics.
  logic [31:0] r_old;
  bit          r_inj;
  exp_t        e0, e1;
  always @(posedge clock) begin
    cyc++;
    if (reset_n) begin
      if (clear_left > 0) begin
        m_mem[DEPTH - clear_left] = '0;
        m_inj[DEPTH - clear_left] = 1'b0;
        clear_left--;
      end else begin
        if (rd_en) begin
          r_old   = m_mem[rd_addr];
          r_inj   = m_inj[rd_addr];
          e0.data = r_old;
          e0.perr = perr_of(r_inj);
          e0.due  = cyc;
          e1.data = r_old;
          if (wr_en && wr_addr == rd_addr) begin
            e1.data = merge(r_old, wr_data, wr_be);
            if (wr_be[0]) r_inj = wr_perr_inj;
          end
          e1.perr = perr_of(r_inj);
          e1.due  = cyc + 1;
          q0.push_back(e0);
          q1.push_back(e1);
        end
        if (wr_en) begin
          m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
          if (wr_be[0]) m_inj[wr_addr] = wr_perr_inj;
        end
      end
    end
  end

  task automatic mon(input int id, input logic v, input logic [31:0] d, input logic pe);
    exp_t        e;
    bit          have;
    bit          exp_v;
    logic [31:0] last;
    have  = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (id == 0) ? q0[0] : q1[0];
    exp_v = have && (e.due == cyc);
    last  = (id == 0) ? last_d0 : last_d1;
    chk($sformatf("rd_valid%0d", id), {31'b0, v}, {31'b0, exp_v});
    if (have && e.due <= cyc) begin
      if (id == 0) void'(q0.pop_front());
      else         void'(q1.pop_front());
    end
    if (v) begin
      if (exp_v) begin
        chk($sformatf("rd_data%0d", id), d, e.data);
        chk($sformatf("rd_perr%0d", id), {31'b0, pe}, {31'b0, e.perr});
      end
      if (id == 0) last_d0 = d;
      else         last_d1 = d;
    end else begin
      chk($sformatf("rd_data_hold%0d", id), d, last);
      chk($sformatf("rd_perr_idle%0d", id), {31'b0, pe}, 32'd0);
    end
  endtask

  // Monitor: outputs change on the rising edge and are sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_valid0", {31'b0, rd_valid0}, 32'd0);
      chk("rst_valid1", {31'b0, rd_valid1}, 32'd0);
      chk("rst_data0", rd_data0, 32'd0);
      chk("rst_data1", rd_data1, 32'd0);
      chk("rst_busy0", {31'b0, init_busy0}, 32'd1);
      chk("rst_busy1", {31'b0, init_busy1}, 32'd1);
      last_d0 = '0;
      last_d1 = '0;
    end else begin
      chk("init_busy0", {31'b0, init_busy0}, {31'b0, clear_left > 0});
      chk("init_busy1", {31'b0, init_busy1}, {31'b0, clear_left > 0});
      mon(0, rd_valid0, rd_data0, rd_perr0);
      mon(1, rd_valid1, rd_data1, rd_perr1);
    end
  end

  // One sampled cycle of stimulus, applied on the falling edge.
  task automatic drive(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic inj,
                       input logic re, input logic [2:0] ra);
    @(negedge clock);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; wr_perr_inj = inj;
    rd_en = re; rd_addr = ra;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic rnd_cycle();
    logic [2:0] wa;
    logic [2:0] ra;
    wa = 3'($urandom_range(0, 7));
    ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
    drive(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom_range(0, 4) == 0),
          1'($urandom), ra);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; wr_perr_inj = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    idle(3);
    @(negedge clock);
    #2 reset_n = 1'b1;

    // Requests during the clear window must be ignored.
    for (int i = 0; i < 7; i++) rnd_cycle();
    idle(2);

    // After clear, every word reads as zero.
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'(a));
    idle(3);

    // Byte-enable merge.
    drive(1'b1, 3'd2, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 3'd2, 32'h11223344, 4'b0101, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'd2);
    idle(3);

    // Back-to-back pipelined reads.
    drive(1'b1, 3'd1, 32'h1, 4'hF, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 3'd2, 32'h2, 4'hF, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 3'd3, 32'h3, 4'hF, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'd1);
    drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'd2);
    drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'd3);
    idle(3);

    // Same-address collision, then a follow-up read.
    drive(1'b1, 3'd5, 32'h0000FFFF, 4'hF, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 3'd5, 32'h12345678, 4'b1100, 1'b0, 1'b1, 3'd5);
    drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'd5);
    idle(3);

    // Parity injection and repair on address 0.
    drive(1'b1, 3'd0, 32'h000000FF, 4'hF, 1'b1, 1'b0, 3'd0);
    drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'd0);
    drive(1'b1, 3'd0, 32'h000000FF, 4'hF, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'd0);
    idle(3);

    // Random traffic with frequent same-address collisions.
    for (int i = 0; i < 400; i++) rnd_cycle();
    idle(3);

    // Reset in the middle of the clear window restarts it from zero.
    @(negedge clock);
    #2 reset_n = 1'b0;
    idle(2);
    @(negedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) rnd_cycle();
    @(negedge clock);
    #2 reset_n = 1'b0;
    idle(2);
    @(negedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 7; i++) rnd_cycle();
    idle(2);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b1, 3'(a));
    for (int i = 0; i < 200; i++) rnd_cycle();
    idle(5);

    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
